pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 15 +
 rtl/pipe_adder_adder_slice.sv | 26 ++
 rtl/pipe_adder.sv | 131 +++++++++++++
 tb/tb_pipe_adder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types for the pipelined adder: operation select and result flags.
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/pipe_adder_adder_slice.sv
// Combinational N-bit ripple chunk; msb_cin is the carry into the top bit.
module adder_slice #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         msb_cin
);
    logic c;

    always_comb begin
        s       = '0;
        msb_cin = 1'b0;
        c       = cin;
        for (int unsigned i = 0; i < N; i++) begin
            if (i == N - 1) msb_cin = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined adder/subtractor, one WIDTH/STAGES-bit slice per stage.
// Optional macro PIPE_ADDER_SAT_EN saturates the result on signed overflow.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  op_t              in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] ONES = '1;

    if (WIDTH < 4 || WIDTH > 64 || STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be 4..64 and a multiple of STAGES");
    end

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             adv;

    // Stage registers; a/b carry the operands forward, s collects finished chunks.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [WIDTH-1:0] s_n [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];
    logic [CW-1:0]    cs  [STAGES];
    logic             cc  [STAGES];
    logic             cm  [STAGES];

    assign b_eff    = (in_op == OP_SUB) ? ~in_b : in_b;
    assign cin_eff  = in_cin ^ (in_op == OP_SUB);
    assign in_ready = !(out_valid && !out_ready);
    assign adv      = in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - CW)) << (k * CW);

        if (k == 0) begin : g_head
            assign a_d[k] = in_a;
            assign b_d[k] = b_eff;
            assign s_d[k] = '0;
            assign c_d[k] = cin_eff;
            assign v_d[k] = in_valid;
        end else begin : g_body
            assign a_d[k] = a_q[k-1];
            assign b_d[k] = b_q[k-1];
            assign s_d[k] = s_q[k-1];
            assign c_d[k] = c_q[k-1];
            assign v_d[k] = v_q[k-1];
        end

        adder_slice #(.N(CW)) u_slice (
            .a       (a_d[k][k*CW +: CW]),
            .b       (b_d[k][k*CW +: CW]),
            .cin     (c_d[k]),
            .s       (cs[k]),
            .cout    (cc[k]),
            .msb_cin (cm[k])
        );

        assign s_n[k] = (s_d[k] & ~MASK) | (WIDTH'(cs[k]) << (k * CW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
                c_q[i] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                v_q[i] <= v_d[i];
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
                s_q[i] <= s_n[i];
                c_q[i] <= cc[i];
            end
            // Carry into the msb differs from carry out exactly on signed overflow.
            ovf_q <= cm[LAST] ^ cc[LAST];
        end
    end

    logic [WIDTH-1:0] sum_fin;
    flags_t           flags;

`ifdef PIPE_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = ONES >> 1;
    always_comb begin
        sum_fin = s_q[LAST];
        if (ovf_q) sum_fin = a_q[LAST][WIDTH-1] ? ~SMAX : SMAX;
    end
`else
    assign sum_fin = s_q[LAST];
`endif

    assign out_valid = v_q[LAST];
    assign flags     = '{cout: c_q[LAST], ovf: ovf_q, zero: v_q[LAST] && (sum_fin == '0)};
    assign out_sum   = sum_fin;
    assign out_cout  = flags.cout;
    assign out_ovf   = flags.ovf;
    assign out_zero  = flags.zero;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder at WIDTH=16, STAGES=4 (honours PIPE_ADDER_SAT_EN).
module tb_pipe_adder;
    import pipe_adder_pkg::*;

`ifdef PIPE_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    op_t         in_op = OP_ADD;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout, out_ovf, out_zero;

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        op_t         op;
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    exp_t exp_q[$];
    vec_t strm[8];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ready_low = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Result monitor: every emitted beat must match the oldest accepted beat.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !in_ready) ready_low++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum",  64'(out_sum),  64'(e.s));
                check("cout", 64'(out_cout), 64'(e.c));
                check("ovf",  64'(out_ovf),  64'(e.o));
                check("zero", 64'(out_zero), 64'(e.z));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input op_t op,
                        input logic [15:0] es, input logic ec, input logic eo, input logic ez);
        logic acc;
        exp_t e;
        in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        if (acc) begin
            e.s = es; e.c = ec; e.o = eo; e.z = ez;
            exp_q.push_back(e);
        end else begin
            check("accept_timeout", 64'd0, 64'd1);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic lat_check(input string tag);
        int lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check(tag, 64'(lat), 64'd4);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    int rl0;
    int seen;

    initial begin
        strm[0] = '{16'h0001, 16'h0002, 1'b0, OP_ADD, 16'h0003, 1'b0, 1'b0, 1'b0};
        strm[1] = '{16'h00FF, 16'h0001, 1'b1, OP_ADD, 16'h0101, 1'b0, 1'b0, 1'b0};
        strm[2] = '{16'h1000, 16'h0001, 1'b0, OP_SUB, 16'h0FFF, 1'b1, 1'b0, 1'b0};
        strm[3] = '{16'h8000, 16'h8000, 1'b0, OP_ADD, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT};
        strm[4] = '{16'h0003, 16'h0003, 1'b1, OP_SUB, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        strm[5] = '{16'h1234, 16'h4321, 1'b0, OP_ADD, 16'h5555, 1'b0, 1'b0, 1'b0};
        strm[6] = '{16'hFFFF, 16'hFFFF, 1'b0, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1};
        strm[7] = '{16'h0F0F, 16'hF0F0, 1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};

        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sum",   64'(out_sum),   64'd0);
        check("rst_cout",  64'(out_cout),  64'd0);
        check("rst_ovf",   64'(out_ovf),   64'd0);
        check("rst_zero",  64'(out_zero),  64'd0);
        check("rst_ready", 64'(in_ready),  64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
        lat_check("latency_first");
        drain();

        send(16'h7FFF, 16'h0001, 1'b0, OP_ADD, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, OP_SUB, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0);
        drain();

        rl0 = ready_low;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(strm[i].a, strm[i].b, strm[i].cin, strm[i].op,
                         strm[i].s, strm[i].c, strm[i].o, strm[i].z);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                check("stall_valid", 64'(out_valid), 64'd1);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_hold_sum", 64'(out_sum), 64'h0101);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", 64'(ready_low - rl0), 64'd3);

        send(16'h0011, 16'h0022, 1'b0, OP_ADD, 16'h0033, 1'b0, 1'b0, 1'b0);
        send(16'h0100, 16'h0200, 1'b0, OP_ADD, 16'h0300, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("pre_rst_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_sum",   64'(out_sum),   64'd0);
        check("async_rst_ready", 64'(in_ready),  64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_no_beat", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        send(16'h0123, 16'h0001, 1'b1, OP_ADD, 16'h0125, 1'b0, 1'b0, 1'b0);
        lat_check("latency_after_rst");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
